// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind UartRx: synchronises the frame-valid level, pushes one
// byte per rising edge into a first-word-fall-through FIFO, and drops/counts bytes when full.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     rxData,
  input  logic                      rxDataIsValid,
  output logic [DATA_WIDTH-1:0]     rdData,
  output logic                      rdValid,
  input  logic                      rdReady,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  output logic [7:0]                dropCount,
  input  logic                      clearOverflow
);
  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   sync_prev;
  logic                   push_req;
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   pop, accept, drop;

  // Flops reset to 1 so a level already high at reset release is not seen as a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '1;
      sync_prev <= 1'b1;
    end else begin
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], rxDataIsValid};
      sync_prev <= vld_pipe[SYNC_STAGES-1];
    end
  end

  assign push_req = vld_pipe[SYNC_STAGES-1] & ~sync_prev;

  assign rdValid = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdData  = mem[rd_ptr[AW-1:0]];

  assign pop    = rdValid & rdReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign accept = push_req & (~full | pop);
  assign drop   = push_req & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= rxData;
  end

  // A drop in the clearing cycle wins and restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clearOverflow)          dropCount <= 8'd1;
      else if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
    end else if (clearOverflow) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: latency, FWFT order, overflow/drop, full push+pop, reset.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxDataIsValid;
  logic [7:0] rdData;
  logic       rdValid;
  logic       rdReady;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] dropCount;
  logic       clearOverflow;

  int nvec = 0;
  int nerr = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxDataIsValid(rxDataIsValid),
    .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady), .count(count),
    .full(full), .overflow(overflow), .dropCount(dropCount), .clearOverflow(clearOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise the level for 3 cycles (write lands on the 3rd edge), then low long enough
  // for the synchroniser to see the next rise as a new frame.
  task automatic push_byte(input logic [7:0] d);
    rxData = d;
    rxDataIsValid = 1'b1;
    repeat (3) tick();
    rxDataIsValid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    rst = 1'b1; rxData = '0; rxDataIsValid = 1'b0; rdReady = 1'b0; clearOverflow = 1'b0;
    repeat (2) tick();
    chk("rst_rdValid", rdValid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropCount", dropCount, 0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: 5-cycle pulse -> one push, visible after the 3rd edge
    rxData = 8'hA5; rxDataIsValid = 1'b1;
    repeat (2) tick();
    chk("t1_no_bypass", rdValid, 0);
    tick();
    chk("t1_rdValid_edge3", rdValid, 1);
    chk("t1_rdData", rdData, 8'hA5);
    repeat (2) tick();
    rxDataIsValid = 1'b0;
    repeat (2) tick();
    chk("t1_one_push", count, 1);
    chk("t1_hold", rdData, 8'hA5);
    rdReady = 1'b1; tick(); rdReady = 1'b0;
    chk("t1_pop_rdValid", rdValid, 0);
    chk("t1_pop_count", count, 0);
    rdReady = 1'b1; tick(); rdReady = 1'b0;
    chk("t1_pop_empty_ignored", count, 0);

    // 2: level high across reset release
    rxDataIsValid = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    repeat (6) tick();
    chk("t2_no_push", count, 0);
    rxDataIsValid = 1'b0;
    repeat (2) tick();

    // 3: fill
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("t3_full", full, 1);
    chk("t3_count", count, 16);

    // 4: drops while full, clear, drop-beats-clear, saturation
    for (int i = 0; i < 3; i++) push_byte(8'hEE);
    chk("t4_overflow", overflow, 1);
    chk("t4_dropCount", dropCount, 3);
    chk("t4_count", count, 16);
    chk("t4_head", rdData, 8'h00);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    chk("t4_clr_overflow", overflow, 0);
    chk("t4_clr_dropCount", dropCount, 0);
    push_byte(8'hEE); push_byte(8'hEE);
    rxData = 8'hEE; rxDataIsValid = 1'b1;
    repeat (2) tick();
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    rxDataIsValid = 1'b0; repeat (2) tick();
    chk("t4_drop_wins_ovf", overflow, 1);
    chk("t4_drop_wins_cnt", dropCount, 1);
    for (int i = 0; i < 256; i++) push_byte(8'hEE);
    chk("t4_saturate", dropCount, 255);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_order_%0d", i), rdData, i);
      rdReady = 1'b1; tick(); rdReady = 1'b0;
    end
    chk("t3_empty", rdValid, 0);

    // 5: full, push coincides with pop
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    chk("t5_full", count, 16);
    rxData = 8'h77; rxDataIsValid = 1'b1;
    repeat (2) tick();
    rdReady = 1'b1; tick(); rdReady = 1'b0;
    chk("t5_count", count, 16);
    chk("t5_no_drop", overflow, 0);
    rxDataIsValid = 1'b0; repeat (2) tick();
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t5_order_%0d", i), rdData, 8'h10 + i);
      rdReady = 1'b1; tick(); rdReady = 1'b0;
    end
    chk("t5_last", rdData, 8'h77);
    rdReady = 1'b1; tick(); rdReady = 1'b0;
    chk("t5_empty", rdValid, 0);

    // 6: async reset mid-stream
    for (int i = 0; i < 7; i++) push_byte(8'(8'h50 + i));
    chk("t6_count7", count, 7);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rdValid", rdValid, 0);
    chk("t6_async_count", count, 0);
    tick(); rst = 1'b0;
    repeat (2) tick();
    push_byte(8'h3C);
    chk("t6_first", rdData, 8'h3C);
    chk("t6_count1", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
